ps2_host_tx: RTL

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DAT pair used by the existing receive path. It runs the request-to-send sequence, shifts out start/data/parity/stop on device-generated clocks, and checks the device ACK. While it is busy, the receive path ignores the bus.

---
 rtl/ps2_host_tx_pkg.sv | 13 +
 rtl/ps2_sync_edge.sv | 16 +
 rtl/ps2_host_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared PS/2 state encodings, command constants and frame helpers
package ps2_host_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR} state_e;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam int FRAME_BITS = 11;
  // {odd parity, data}: the nine bits shifted out after the start bit
  function automatic logic [8:0] frame_payload(input logic [7:0] d);
    return {~^d, d};
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchroniser with a registered previous value and falling-edge pulse
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;
  // idle bus is high, so reset to 1 to avoid a spurious edge after reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) {meta_q, sync_q, prev_q} <= 3'b111;
    else {meta_q, sync_q, prev_q} <= {d_i, meta_q, sync_q};
  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STOP_IDX = 4'(FRAME_BITS - 2);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] shift_q, shift_d;
  logic clk_low_q, clk_low_d, dat_low_q, dat_low_d;
  logic clk_sync, clk_fall, dat_meta_q, dat_sync_q;
  ps2_sync_edge u_clk_sync (
    .clk_i (CLOCK_50),
    .rst_i (reset),
    .d_i   (PS2_CLK),
    .sync_o(clk_sync),
    .fall_o(clk_fall)
  );
  // data line only needs a plain synchroniser for the ACK sample and idle check
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) {dat_meta_q, dat_sync_q} <= 2'b11;
    else {dat_meta_q, dat_sync_q} <= {PS2_DAT, dat_meta_q};
  // state and datapath registers; line enables are registered so the pads never glitch
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
    end
  // next-state: request-to-send, shift on device clock falls, ACK check, timeout override
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;
    case (state_q)
      IDLE: if (tx_start) begin
        state_d   = INHIBIT;
        shift_d   = frame_payload(tx_data);
        cnt_d     = '0;
        clk_low_d = 1'b1;
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          state_d   = REQ;
          dat_low_d = 1'b1;
        end
      end
      REQ: begin
        state_d   = SHIFT;
        clk_low_d = 1'b0;
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
      SHIFT: if (clk_fall) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        dat_low_d = (bit_cnt_q == STOP_IDX) ? 1'b0 : ~shift_q[0];
        shift_d   = {1'b0, shift_q[8:1]};
        state_d   = (bit_cnt_q == STOP_IDX) ? ACK : SHIFT;
      end
      ACK: if (clk_fall) state_d = dat_sync_q ? ERR : WAIT_IDLE;
      WAIT_IDLE: if (clk_sync && dat_sync_q) state_d = DONE;
      default: begin
        state_d   = IDLE;
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
      end
    endcase
    if (state_q == SHIFT || state_q == ACK || state_q == WAIT_IDLE) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TO_LAST) begin
        state_d   = ERR;
        dat_low_d = 1'b0;
      end
    end
  end
  assign busy     = state_q != IDLE;
  assign tx_done  = state_q == DONE;
  assign tx_error = state_q == ERR;
  assign PS2_CLK  = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT  = dat_low_q ? 1'b0 : 1'bz;
endmodule
